l1_veri_onbellegi: RTL

//  Direct-mapped, write-through, no-write-allocate L1 data cache directly downstream of the

---
 rtl/l1_veri_onbellegi_if.sv | 33 +++
 rtl/l1_veri_onbellegi.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/l1_veri_onbellegi_if.sv
// Bundle of the load/store-unit request side and the main-memory side of the L1 data cache.
// "slave" is the cache's view; "master" is the view of whoever drives requests and plays memory.
interface l1_veri_onbellegi_if;
  logic        l1v_sec_n_i;
  logic        l1v_yaz_gecerli_i;
  logic [31:0] l1v_adr_i;
  logic [31:0] l1v_veri_i;
  logic [3:0]  l1v_veri_maske_i;
  logic [31:0] l1v_veri_o;
  logic        l1v_durdur_o;
  logic        bellek_istek_o;
  logic        bellek_yaz_o;
  logic [31:0] bellek_adr_o;
  logic [31:0] bellek_veri_o;
  logic [3:0]  bellek_maske_o;
  logic        bellek_hazir_i;
  logic        bellek_gecerli_i;
  logic [31:0] bellek_veri_i;

  modport slave (
    input  l1v_sec_n_i, l1v_yaz_gecerli_i, l1v_adr_i, l1v_veri_i, l1v_veri_maske_i,
    output l1v_veri_o, l1v_durdur_o,
    output bellek_istek_o, bellek_yaz_o, bellek_adr_o, bellek_veri_o, bellek_maske_o,
    input  bellek_hazir_i, bellek_gecerli_i, bellek_veri_i
  );

  modport master (
    output l1v_sec_n_i, l1v_yaz_gecerli_i, l1v_adr_i, l1v_veri_i, l1v_veri_maske_i,
    input  l1v_veri_o, l1v_durdur_o,
    input  bellek_istek_o, bellek_yaz_o, bellek_adr_o, bellek_veri_o, bellek_maske_o,
    output bellek_hazir_i, bellek_gecerli_i, bellek_veri_i
  );
endinterface

// File: rtl/l1_veri_onbellegi.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache with a single-outstanding
// word-wide memory port; read misses refill the whole line one word at a time.
module l1_veri_onbellegi #(
  parameter int SATIR_SAYISI = 16,
  parameter int BLOK_KELIME  = 4
) (
  input logic                clk_i,
  input logic                rst_ni,
  l1_veri_onbellegi_if.slave bus
);
  localparam int SB = $clog2(SATIR_SAYISI);
  localparam int KB = $clog2(BLOK_KELIME);
  localparam int DW = SB + KB;
  localparam int TW = 30 - DW;

  typedef enum logic [2:0] {
    BOSTA, KARSILASTIR, DOLDUR_ISTEK, DOLDUR_BEKLE, YAZ_ISTEK, YAZ_BEKLE
  } durum_t;

  durum_t            durum_reg, durum_next;
  logic [KB-1:0]     k_reg, k_next;
  logic [29:0]       adr_reg;
  logic [31:0]       veri_reg;
  logic [3:0]        maske_reg;
  logic              yaz_reg;
  logic [SATIR_SAYISI-1:0] gecerli_reg;
  logic [TW-1:0]     etiket_mem [SATIR_SAYISI];
  logic [31:0]       istenen_reg, cikis_reg, cikis_c;
  logic              durdur_c;
  logic              bellek_istek_reg, bellek_yaz_reg;
  logic [31:0]       bellek_adr_reg, bellek_veri_reg;
  logic [3:0]        bellek_maske_reg;

  logic              ram_yaz, ram_oku;
  logic [DW-1:0]     ram_yaz_adr, ram_oku_adr;
  logic [31:0]       ram_yaz_veri, okunan_kelime;
  logic [3:0]        ram_serit;

  logic [KB-1:0]     ofs;
  logic [SB-1:0]     idx;
  logic [TW-1:0]     etiket;
  logic              isabet, son_kelime, dolum_yaz;
  logic              unused_adr;

  assign ofs        = adr_reg[KB-1:0];
  assign idx        = adr_reg[DW-1:KB];
  assign etiket     = adr_reg[29:DW];
  assign isabet     = gecerli_reg[idx] && (etiket_mem[idx] == etiket);
  assign son_kelime = (k_reg == KB'(BLOK_KELIME - 1));
  assign dolum_yaz  = (durum_reg == DOLDUR_BEKLE) && bus.bellek_gecerli_i;
  assign unused_adr = ^bus.l1v_adr_i[1:0];

  // Data RAM is read in the accept cycle so the word is ready for the compare cycle.
  assign ram_oku     = (durum_reg == BOSTA) && !bus.l1v_sec_n_i;
  assign ram_oku_adr = bus.l1v_adr_i[DW+1:2];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_serit
      logic [7:0] bayt_mem [SATIR_SAYISI*BLOK_KELIME];
      logic [7:0] okunan_bayt;
      always_ff @(posedge clk_i) begin
        if (ram_yaz && ram_serit[gi]) bayt_mem[ram_yaz_adr] <= ram_yaz_veri[8*gi +: 8];
        if (ram_oku) okunan_bayt <= bayt_mem[ram_oku_adr];
      end
      assign okunan_kelime[8*gi +: 8] = okunan_bayt;
    end
  endgenerate

  always_comb begin
    durum_next   = durum_reg;
    k_next       = k_reg;
    durdur_c     = 1'b0;
    cikis_c      = cikis_reg;
    ram_yaz      = 1'b0;
    ram_yaz_adr  = {idx, ofs};
    ram_yaz_veri = veri_reg;
    ram_serit    = maske_reg;
    case (durum_reg)
      BOSTA: begin
        if (!bus.l1v_sec_n_i) begin
          durdur_c   = 1'b1;
          durum_next = KARSILASTIR;
        end
      end
      KARSILASTIR: begin
        if (yaz_reg) begin
          durdur_c   = 1'b1;
          ram_yaz    = isabet;
          durum_next = YAZ_ISTEK;
        end else if (isabet) begin
          cikis_c    = okunan_kelime;
          durum_next = BOSTA;
        end else begin
          durdur_c   = 1'b1;
          k_next     = '0;
          durum_next = DOLDUR_ISTEK;
        end
      end
      DOLDUR_ISTEK: begin
        durdur_c = 1'b1;
        if (bus.bellek_hazir_i) durum_next = DOLDUR_BEKLE;
      end
      DOLDUR_BEKLE: begin
        durdur_c = 1'b1;
        if (bus.bellek_gecerli_i) begin
          ram_yaz      = 1'b1;
          ram_yaz_adr  = {idx, k_reg};
          ram_yaz_veri = bus.bellek_veri_i;
          ram_serit    = 4'hF;
          if (son_kelime) begin
            durdur_c   = 1'b0;
            cikis_c    = (k_reg == ofs) ? bus.bellek_veri_i : istenen_reg;
            durum_next = BOSTA;
          end else begin
            k_next     = k_reg + 1'b1;
            durum_next = DOLDUR_ISTEK;
          end
        end
      end
      YAZ_ISTEK: begin
        if (bus.bellek_hazir_i) durum_next = BOSTA;
        else durdur_c = 1'b1;
      end
      default: durum_next = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      durum_reg        <= BOSTA;
      k_reg            <= '0;
      gecerli_reg      <= '0;
      cikis_reg        <= '0;
      bellek_istek_reg <= 1'b0;
      bellek_yaz_reg   <= 1'b0;
      bellek_adr_reg   <= '0;
      bellek_veri_reg  <= '0;
      bellek_maske_reg <= '0;
    end else begin
      durum_reg <= durum_next;
      k_reg     <= k_next;
      cikis_reg <= cikis_c;
      // The line is invalidated while being refilled so a half-written line is never hit.
      if (durum_reg == KARSILASTIR && !yaz_reg && !isabet) gecerli_reg[idx] <= 1'b0;
      if (dolum_yaz && son_kelime) gecerli_reg[idx] <= 1'b1;
      bellek_istek_reg <= (durum_next == DOLDUR_ISTEK) || (durum_next == YAZ_ISTEK);
      bellek_yaz_reg   <= (durum_next == YAZ_ISTEK);
      if (durum_next == DOLDUR_ISTEK) begin
        bellek_adr_reg   <= {etiket, idx, k_next, 2'b00};
        bellek_veri_reg  <= '0;
        bellek_maske_reg <= 4'hF;
      end else if (durum_next == YAZ_ISTEK) begin
        bellek_adr_reg   <= {adr_reg, 2'b00};
        bellek_veri_reg  <= veri_reg;
        bellek_maske_reg <= maske_reg;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (ram_oku) begin
      adr_reg   <= bus.l1v_adr_i[31:2];
      veri_reg  <= bus.l1v_veri_i;
      maske_reg <= bus.l1v_veri_maske_i;
      yaz_reg   <= bus.l1v_yaz_gecerli_i;
    end
    if (dolum_yaz && (k_reg == ofs)) istenen_reg <= bus.bellek_veri_i;
    if (dolum_yaz && son_kelime) etiket_mem[idx] <= etiket;
  end

  assign bus.l1v_veri_o     = cikis_c;
  assign bus.l1v_durdur_o   = durdur_c & rst_ni;
  assign bus.bellek_istek_o = bellek_istek_reg;
  assign bus.bellek_yaz_o   = bellek_yaz_reg;
  assign bus.bellek_adr_o   = bellek_adr_reg;
  assign bus.bellek_veri_o  = bellek_veri_reg;
  assign bus.bellek_maske_o = bellek_maske_reg;
endmodule
